// File: rtl/fir_decim_sink.sv
// fir_decim_sink: drops FIR warm-up, normalises, rounds, saturates, decimates
// and queues results in a small FIFO behind a valid/ready output port.
//
// Ports: clk; Reset (async, active low); Data_in/in_valid (no backpressure);
// Data_out/out_valid/out_ready (FIFO head); fifo_level; overflow (sticky).
// Option macro FIR_DECIM_ACCUM_EN: integrate-and-dump instead of pick-one.
module fir_decim_sink #(
  parameter int IN_SIZE    = 32,
  parameter int OUT_SIZE   = 16,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [IN_SIZE-1:0]            Data_in,
  input  logic                          in_valid,
  output logic [OUT_SIZE-1:0]           Data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PW = $clog2(DECIM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(WARMUP + 1);
  localparam int SW = IN_SIZE + 1;

  logic [WW-1:0]       warm_q, warm_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic                ovf_q, ovf_d;
  logic [OUT_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [OUT_SIZE-1:0] mem_d [FIFO_DEPTH];

  logic          warm_done;
  logic [SW-1:0] sum;
  logic [SW-1:0] s;
  logic          keep;
  logic          full;
  logic          pop;
  logic          push;
  logic [OUT_SIZE-1:0] sat;

  // Extra top bit keeps the rounding carry out of Data_in.
  assign sum = {1'b0, Data_in} + (SW'(1) << (SHIFT - 1));
  assign s   = sum >> SHIFT;

  assign warm_done = (warm_q == WW'(WARMUP));

`ifdef FIR_DECIM_ACCUM_EN
  localparam int AC = IN_SIZE + PW + 1;

  logic [AC-1:0] acc_q, acc_d;
  logic [AC-1:0] tot;
  logic [AC-1:0] pre;

  assign keep = in_valid && warm_done &&
                (phase_q == PW'(DECIM - 1));
  assign tot  = acc_q + AC'(s) + AC'(DECIM / 2);
  assign pre  = tot >> PW;
  assign sat  = (pre > AC'({OUT_SIZE{1'b1}})) ?
                '1 : pre[OUT_SIZE-1:0];

  always_comb begin
    acc_d = acc_q;
    if (in_valid && warm_done) begin
      if (keep) acc_d = '0;
      else      acc_d = acc_q + AC'(s);
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  assign keep = in_valid && warm_done && (phase_q == '0);
  assign sat  = (s > SW'({OUT_SIZE{1'b1}})) ?
                '1 : s[OUT_SIZE-1:0];
`endif

  assign out_valid  = (lvl_q != '0);
  assign full       = (lvl_q == LW'(FIFO_DEPTH));
  assign pop        = out_valid && out_ready;
  // A pop frees the slot the same cycle, so a full FIFO still takes it.
  assign push       = keep && (!full || pop);
  assign Data_out   = out_valid ? mem_q[rd_q] : '0;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;

  always_comb begin
    warm_d  = warm_q;
    phase_d = phase_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    mem_d   = mem_q;
    if (in_valid) begin
      if (!warm_done) warm_d  = warm_q + WW'(1);
      else            phase_d = phase_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_q] = sat;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    unique case (1'b1)
      push && !pop: lvl_d = lvl_q + LW'(1);
      pop && !push: lvl_d = lvl_q - LW'(1);
      default:      lvl_d = lvl_q;
    endcase
    if (keep && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      warm_q  <= '0;
      phase_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      warm_q  <= warm_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_fir_decim_sink.sv
// tb_fir_decim_sink: table vectors plus hand sequences; a queue holds the
// expected FIFO contents and is popped whenever the DUT hands a sample out.
module tb_fir_decim_sink;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] Data_in;
  logic        in_valid;
  logic [15:0] Data_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          nacc;
  bit          m_ovf;
  logic [15:0] q[$];

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  fir_decim_sink dut (
    .clk        (clk),
    .Reset      (Reset),
    .Data_in    (Data_in),
    .in_valid   (in_valid),
    .Data_out   (Data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit is_keep(input int n);
    if (n < 8) return 1'b0;
`ifdef FIR_DECIM_ACCUM_EN
    return ((n - 8) % 4) == 3;
`else
    return ((n - 8) % 4) == 0;
`endif
  endfunction

  // One clock: drive at posedge+1, observe handshake at negedge,
  // check state at the following posedge+1.
  task automatic cycle(input bit v,
                       input logic [31:0] d,
                       input bit r,
                       input logic [15:0] e);
    in_valid  = v;
    Data_in   = d;
    out_ready = r;
    if (v) begin
      if (is_keep(nacc)) begin
        if (q.size() < 4 || (r && q.size() > 0))
          q.push_back(e);
        else
          m_ovf = 1'b1;
      end
      nacc++;
    end
    @(negedge clk);
    if (out_valid) begin
      if (out_ready) begin
        chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0)
          chk("pop_data", 32'(Data_out), 32'(q.pop_front()));
      end
    end else begin
      chk("dout_idle", 32'(Data_out), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Data_in   = '0;
    #2;
    chk("rst_dout",  32'(Data_out),   32'd0);
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    Reset = 1'b1;
    q.delete();
    nacc  = 0;
    m_ovf = 1'b0;
  endtask

  task automatic kept_sample(input logic [31:0] d,
                             input logic [15:0] e,
                             input bit r);
    while (!is_keep(nacc))
      cycle(1'b1, 32'd0, 1'b0, 16'd0);
    cycle(1'b1, d, r, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++)
      cycle(1'b0, 32'd0, 1'b1, 16'd0);
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'd127,        16'd0};
    tbl[1] = '{32'd128,        16'd1};
    tbl[2] = '{32'hFFFF_FFFF,  16'hFFFF};
    tbl[3] = '{32'h00FF_FF00,  16'hFFFF};
    tbl[4] = '{32'h00FF_FF7F,  16'hFFFF};
    tbl[5] = '{32'h00FF_FE7F,  16'hFFFE};
    tbl[6] = '{32'hFFFF_FF80,  16'hFFFF};
    tbl[7] = '{32'd25600,      16'd100};
    tbl[8] = '{32'd0,          16'd0};
    tbl[9] = '{32'd383,        16'd1};

    Reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Data_in   = '0;
    @(posedge clk);
    #1;
    do_reset();

`ifndef FIR_DECIM_ACCUM_EN
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'd25600, 1'b1, 16'd100);
    chk("t1_warm_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 32'd25600, 1'b1, 16'd100);
    chk("t1_first_dout",  32'(Data_out),  32'd100);
    chk("t1_first_valid", 32'(out_valid), 32'd1);

    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'd25600, 1'b1, 16'd100);
      chk("t2_level_le1", 32'(fifo_level <= 3'd1), 32'd1);
    end
    cycle(1'b0, 32'd99, 1'b0, 16'd0);
    drain();

    for (int i = 0; i < 10; i++) begin
      kept_sample(tbl[i].din, tbl[i].dout, 1'b1);
      cycle(1'b0, 32'd0, 1'b0, 16'd0);
    end
    drain();

    do_reset();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'd0, 1'b0, 16'd0);
    for (int i = 0; i < 24; i++)
      cycle(1'b1, 32'((i + 1) * 256), 1'b0, 16'(i + 1));
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_ovf",   32'(overflow),   32'd1);
    chk("t4_head",  32'(Data_out),   32'd1);

    kept_sample(32'(25 * 256), 16'd25, 1'b1);
    chk("t5_level", 32'(fifo_level), 32'd4);
    chk("t5_head",  32'(Data_out),   32'd5);

    cycle(1'b0, 32'd0, 1'b1, 16'd0);
    chk("t6_pre_level", 32'(fifo_level), 32'd3);
    do_reset();
    cycle(1'b0, 32'd0, 1'b0, 16'd0);
    chk("t6_post_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'd25600, 1'b0, 16'd100);
    chk("t6_warm_level", 32'(fifo_level), 32'd0);
    cycle(1'b1, 32'd25600, 1'b0, 16'd100);
    chk("t6_restart", 32'(Data_out), 32'd100);
    drain();
`else
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'd0, 1'b0, 16'd0);
    cycle(1'b1, 32'd256,  1'b0, 16'd3);
    cycle(1'b1, 32'd512,  1'b0, 16'd3);
    cycle(1'b1, 32'd768,  1'b0, 16'd3);
    chk("acc_wait", 32'(out_valid), 32'd0);
    cycle(1'b1, 32'd1024, 1'b0, 16'd3);
    chk("acc_avg", 32'(Data_out), 32'd3);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'd25600, 1'b1, 16'd100);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 16'hFFFF);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 16'hFFFF);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 16'hFFFF);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 16'hFFFF);
    drain();
    cycle(1'b1, 32'd256, 1'b0, 16'd0);
    do_reset();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'd0, 1'b0, 16'd0);
    cycle(1'b1, 32'd256,  1'b0, 16'd3);
    cycle(1'b1, 32'd512,  1'b0, 16'd3);
    cycle(1'b1, 32'd768,  1'b0, 16'd3);
    cycle(1'b1, 32'd1024, 1'b0, 16'd3);
    chk("acc_after_rst", 32'(Data_out), 32'd3);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
